// File: rtl/snake_engine_if.sv
// Bundle of the snake engine's control inputs and frame/status outputs.
// The master side (game-rate divider, buttons, scan driver) drives tick and
// the buttons; the slave side (the engine) publishes frames and status.
interface snake_engine_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             tick;
    logic             btn_up;
    logic             btn_right;
    logic             btn_down;
    logic             btn_left;
    logic [63:0]      frame_snake;
    logic [63:0]      frame_food;
    logic [LEN_W-1:0] length;
    logic             game_over;
    logic             running;

    modport master (
        output tick, btn_up, btn_right, btn_down, btn_left,
        input  frame_snake, frame_food, length, game_over, running
    );

    modport slave (
        input  tick, btn_up, btn_right, btn_down, btn_left,
        output frame_snake, frame_food, length, game_over, running
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game logic: body ring buffer, direction control, food placement via
// LFSR search, and the snake/food occupancy bitmaps for the LED scan driver.
module snake_engine #(
    parameter int         MAX_LEN   = 16,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic           clk,
    input logic           rst_n,
    snake_engine_if.slave bus
);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, FOOD, OVER} state_t;

    // Move one cell in the given direction; x and y wrap modulo 8.
    function automatic logic [5:0] step_cell(input logic [5:0] c, input logic [1:0] d);
        logic [2:0] x;
        logic [2:0] y;
        x = c[2:0];
        y = c[5:3];
        case (d)
            DIR_UP:    y = y - 3'd1;
            DIR_RIGHT: x = x + 3'd1;
            DIR_DOWN:  y = y + 3'd1;
            default:   x = x - 3'd1;
        endcase
        return {y, x};
    endfunction

    // 8-bit Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    // Initial body occupies row 3, cells x = 0 .. INIT_LEN-1.
    function automatic logic [63:0] init_frame();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < INIT_LEN; i++) f[24 + i] = 1'b1;
        return f;
    endfunction

    localparam logic [63:0] INIT_FRAME = init_frame();

    state_t         state, state_nx;
    logic [5:0]     body [MAX_LEN];
    logic [PW-1:0]  head_ptr, tail_ptr;
    logic [LW-1:0]  len;
    logic [63:0]    frame, frame_nx;
    logic [5:0]     food;
    logic [7:0]     lfsr, lfsr_nx;
    logic [1:0]     dir_req, dir_last, eff_last, btn_dir;
    logic           pending;
    logic           any_btn, btn_legal, move_req;
    logic [5:0]     head_cell, tail_cell, next_cell;
    logic           eat, grow, collide, cand_free;
    logic           do_move, place;

    // Datapath decode: next head, growth, collision and food candidate.
    always_comb begin
        any_btn   = bus.btn_up | bus.btn_right | bus.btn_down | bus.btn_left;
        btn_dir   = bus.btn_up    ? DIR_UP :
                    bus.btn_right ? DIR_RIGHT :
                    bus.btn_down  ? DIR_DOWN : DIR_LEFT;
        head_cell = body[head_ptr];
        tail_cell = body[tail_ptr];
        next_cell = step_cell(head_cell, dir_req);
        eat       = (next_cell == food);
        grow      = eat && (len < LW'(MAX_LEN));
        // The tail cell vacates on this move unless the snake grows.
        collide   = frame[next_cell] && !(!grow && (next_cell == tail_cell));
        move_req  = bus.tick | pending;
        lfsr_nx   = lfsr_step(lfsr);
        cand_free = !frame[lfsr_nx[5:0]];
        frame_nx  = frame;
        if (!grow) frame_nx[tail_cell] = 1'b0;
        frame_nx[next_cell] = 1'b1;
    end

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        state_nx = state;
        do_move  = 1'b0;
        place    = 1'b0;
        case (state)
            IDLE: if (any_btn) state_nx = RUN;
            RUN: begin
                if (move_req) begin
                    if (collide) begin
                        state_nx = OVER;
                    end else begin
                        do_move = 1'b1;
                        if (eat) state_nx = FOOD;
                    end
                end
            end
            FOOD: begin
                if (cand_free) begin
                    place    = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = OVER;
        endcase
        // On a move edge the direction being applied becomes the reference
        // for the reversal check.
        eff_last  = do_move ? dir_req : dir_last;
        btn_legal = any_btn && (btn_dir != (eff_last ^ 2'd2));
    end

    // Game state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Body ring buffer, frame, food, LFSR, direction and pending-tick state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++)
                body[i] <= (i < INIT_LEN) ? {3'd3, 3'(i)} : 6'd0;
            head_ptr <= PW'(INIT_LEN - 1);
            tail_ptr <= '0;
            len      <= LW'(INIT_LEN);
            frame    <= INIT_FRAME;
            food     <= 6'd29;
            lfsr     <= LFSR_SEED;
            dir_req  <= DIR_RIGHT;
            dir_last <= DIR_RIGHT;
            pending  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (any_btn) dir_req <= btn_dir;
            end else if (state != OVER && btn_legal) begin
                dir_req <= btn_dir;
            end
            if (state == FOOD && bus.tick) pending <= 1'b1;
            else if (do_move)              pending <= 1'b0;
            if (do_move) begin
                dir_last                <= dir_req;
                body[ptr_inc(head_ptr)] <= next_cell;
                head_ptr                <= ptr_inc(head_ptr);
                frame                   <= frame_nx;
                if (grow) len      <= len + LW'(1);
                else      tail_ptr <= ptr_inc(tail_ptr);
            end
            if (state == FOOD) lfsr <= lfsr_nx;
            if (place)         food <= lfsr_nx[5:0];
        end
    end

    assign bus.frame_snake = frame;
    assign bus.frame_food  = (state == FOOD) ? 64'd0 : (64'd1 << food);
    assign bus.length      = len;
    assign bus.game_over   = (state == OVER);
    assign bus.running     = (state == RUN) || (state == FOOD);
endmodule
